decoder_scan_sequencer: RTL and testbench

- Upstream driver for the 3-to-8 decoder: produces its `en` and 3-bit select `x`, so the decoder one-hot outputs scan a set of channels in order.
- Steps through the channels enabled in a mask, holding each for a programmable dwell time.
- Inserts one blanking cycle (`en` = 0) between channels, so the decoder never switches outputs while enabled.
- Supports single-sweep and continuous modes, with a start/stop handshake.

---
 rtl/scan_pkg.sv | 6 +
 rtl/chan_next_sel.sv | 20 ++
 rtl/decoder_scan_sequencer.sv | 132 +++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding and channel constants for the decoder scan sequencer.
package scan_pkg;
    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
endpackage

// File: rtl/chan_next_sel.sv
// chan_next_sel: rotating priority finder for the first enabled channel strictly above x, wrapping to 0.
import scan_pkg::*;
module chan_next_sel (
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] x,
    output logic [SEL_W-1:0] nxt,
    output logic             wraps
);
    logic [SEL_W-1:0] idx;
    always_comb begin
        nxt = x;
        idx = '0;
        // Walk from the farthest offset to the nearest so the nearest set bit wins.
        for (int k = NCH; k >= 1; k--) begin
            idx = x + SEL_W'(k);
            if (mask[idx]) nxt = idx;
        end
        wraps = nxt <= x;
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives en/x of a 3-to-8 decoder to scan masked channels with a dwell
// and one blanking cycle between channels.
import scan_pkg::*;
module decoder_scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               en,
    output logic [SEL_W-1:0]   x,
    output logic               busy,
    output logic               done,
    output logic               wrap
);
    state_t             state_q, state_d;
    logic               en_q, en_d, busy_q, busy_d, done_q, done_d, wrap_q, wrap_d, cont_q, cont_d;
    logic [SEL_W-1:0]   x_q, x_d;
    logic [NCH-1:0]     mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d, cnt_q, cnt_d, dw_in;
    logic               idle;
    logic [NCH-1:0]     sel_mask;
    logic [SEL_W-1:0]   sel_x, nxt;
    logic               wraps;

    // In IDLE/DONE the finder looks at the live mask from x = 7, yielding its lowest set bit.
    assign idle     = state_q == IDLE || state_q == DONE;
    assign sel_mask = idle ? mask : mask_q;
    assign sel_x    = idle ? SEL_W'(NCH - 1) : x_q;
    assign dw_in    = dwell == '0 ? DWELL_W'(1) : dwell;

    chan_next_sel u_next (
        .mask  (sel_mask),
        .x     (sel_x),
        .nxt   (nxt),
        .wraps (wraps)
    );

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        x_d     = x_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        mask_d  = mask_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (!wraps || cont_q) begin
                        state_d = GAP;
                        en_d    = 1'b0;
                        wrap_d  = wraps;
                    end else begin
                        state_d = DONE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                GAP: begin
                    state_d = ACTIVE;
                    x_d     = nxt;
                    en_d    = 1'b1;
                    cnt_d   = dwell_q - DWELL_W'(1);
                end
                default: begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    if (start && mask != '0) begin
                        state_d = ACTIVE;
                        mask_d  = mask;
                        dwell_d = dw_in;
                        cont_d  = cont;
                        x_d     = nxt;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = dw_in - DWELL_W'(1);
                    end else if (start) begin
                        done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en   = en_q;
    assign x    = x_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed scenarios with hand-computed en/x/busy/done/wrap sequences.
module tb_decoder_scan_sequencer;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [7:0] mask = '0, dwell = '0;
    logic       en, busy, done, wrap;
    logic [2:0] x;
    int         checks = 0, errors = 0;

    decoder_scan_sequencer #(.DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .mask(mask), .dwell(dwell), .en(en), .x(x), .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic c);
        mask = m; dwell = d; cont = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        checks++;
        if ({en, x, busy, done, wrap} !== 7'b0) begin
            errors++; $display("FAIL reset_state got en=%b x=%0d busy=%b done=%b wrap=%b need all 0", en, x, busy, done, wrap);
        end
        rst = 1'b0;
        tick();
        launch(8'h04, 8'd5, 1'b0);
        tick();
        checks++;
        if (en !== 1'b1 || x !== 3'd2) begin
            errors++; $display("FAIL pre_reset_active got en=%b x=%0d need en=1 x=2", en, x);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0 || x !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset got en=%b x=%0d busy=%b need 0 0 0", en, x, busy);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle cyc %0d got en=%b busy=%b done=%b need 0", i, en, busy, done);
            end
        end
    endtask

    task automatic test_single_sweep();
        logic [8:0] en_e   = 9'b011011011;
        logic [8:0] busy_e = 9'b011111111;
        logic [8:0] done_e = 9'b100000000;
        logic [2:0] x_e [9] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd7, 3'd7, 3'd7};
        launch(8'b1000_0101, 8'd2, 1'b0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (en !== en_e[i] || x !== x_e[i] || busy !== busy_e[i] || done !== done_e[i]) begin
                errors++;
                $display("FAIL single_sweep cyc %0d got en=%b x=%0d busy=%b done=%b need en=%b x=%0d busy=%b done=%b",
                         i, en, x, busy, done, en_e[i], x_e[i], busy_e[i], done_e[i]);
            end
            tick();
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || en !== 1'b0) begin
            errors++; $display("FAIL single_sweep_after got done=%b busy=%b en=%b need 0 0 0", done, busy, en);
        end
    endtask

    task automatic test_continuous();
        logic [7:0] en_e   = 8'b01010101;
        logic [7:0] wrap_e = 8'b10001000;
        logic [2:0] x_e [8] = '{3'd1, 3'd1, 3'd4, 3'd4, 3'd1, 3'd1, 3'd4, 3'd4};
        launch(8'b0001_0010, 8'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (en !== en_e[i] || x !== x_e[i] || wrap !== wrap_e[i] || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL continuous cyc %0d got en=%b x=%0d wrap=%b busy=%b done=%b need en=%b x=%0d wrap=%b busy=1 done=0",
                         i, en, x, wrap, busy, done, en_e[i], x_e[i], wrap_e[i]);
            end
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL continuous_stop got en=%b busy=%b done=%b wrap=%b need 0", en, busy, done, wrap);
        end
    endtask

    task automatic test_dwell_zero_empty();
        launch(8'h01, 8'd0, 1'b0);
        checks++;
        if (en !== 1'b1 || x !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL dwell0_active got en=%b x=%0d busy=%b need 1 0 1", en, x, busy);
        end
        tick();
        checks++;
        if (en !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL dwell0_done got en=%b done=%b busy=%b need 0 1 0", en, done, busy);
        end
        tick();
        launch(8'h00, 8'd3, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || en !== 1'b0) begin
            errors++; $display("FAIL empty_mask got done=%b busy=%b en=%b need 1 0 0", done, busy, en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL empty_mask_after got done=%b en=%b busy=%b need 0 0 0", done, en, busy);
        end
    endtask

    task automatic test_stop_priority();
        launch(8'h0C, 8'd5, 1'b0);
        repeat (8) tick();
        checks++;
        if (en !== 1'b1 || x !== 3'd3) begin
            errors++; $display("FAIL stop_pre got en=%b x=%0d need en=1 x=3", en, x);
        end
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        checks++;
        if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || x !== 3'd3) begin
            errors++; $display("FAIL stop_edge got en=%b busy=%b done=%b x=%0d need 0 0 0 3", en, busy, done, x);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL stop_idle cyc %0d got en=%b done=%b busy=%b need 0", i, en, done, busy);
            end
        end
        launch(8'h0C, 8'd5, 1'b0);
        checks++;
        if (en !== 1'b1 || x !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL stop_restart got en=%b x=%0d busy=%b need 1 2 1", en, x, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_ignored_inputs();
        logic [5:0] en_e   = 6'b011011;
        logic [5:0] done_e = 6'b100000;
        logic [2:0] x_e [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
        launch(8'h03, 8'd2, 1'b0);
        mask = 8'hFF; dwell = 8'd7; cont = 1'b1; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (en !== en_e[i] || x !== x_e[i] || done !== done_e[i]) begin
                errors++;
                $display("FAIL ignored_inputs cyc %0d got en=%b x=%0d done=%b need en=%b x=%0d done=%b",
                         i, en, x, done, en_e[i], x_e[i], done_e[i]);
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (en !== 1'b1 || x !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL start_in_done got en=%b x=%0d busy=%b done=%b need 1 0 1 0", en, x, busy, done);
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_continuous();
        test_dwell_zero_empty();
        test_stop_priority();
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
